// File: rtl/inscache_pkg.sv
// ---------------------------------------------------------------------------
// inscache_pkg
// Shared definitions for the set-associative instruction cache:
//   state_t    - controller states (IDLE, MEM_READ, UPDATE)
//   WORD_W     - instruction word width in bits
//   log2_ceil  - ceiling log2, usable in constant expressions
// ---------------------------------------------------------------------------
package inscache_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/inscache_lru.sv
// ---------------------------------------------------------------------------
// inscache_lru
// Per-set true-LRU age storage and victim selection.
// Parameters: WAYS (1, 2 or 4), SETS (power of two).
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   idx           - set currently being looked up / updated
//   valid_set     - valid bits of the ways in set idx
//   upd_en        - make upd_way the most-recently-used way of set idx
//   upd_way       - way being accessed (hit or fill)
//   victim        - lowest invalid way of set idx, else its LRU way
// With WAYS=1 no age storage exists and the victim is always way 0.
// ---------------------------------------------------------------------------
module inscache_lru
    import inscache_pkg::*;
#(
    parameter  int WAYS  = 2,
    parameter  int SETS  = 8,
    localparam int IDX_W = log2_ceil(SETS),
    localparam int WAY_W = (WAYS > 1) ? log2_ceil(WAYS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] idx,
    input  logic [WAYS-1:0]  valid_set,
    input  logic             upd_en,
    input  logic [WAY_W-1:0] upd_way,
    output logic [WAY_W-1:0] victim
);

    if (WAYS == 1) begin : g_direct
        logic unused_lru;
        assign unused_lru = ^{clock, reset, idx, valid_set, upd_en, upd_way};
        assign victim     = '0;
    end else begin : g_lru
        localparam int AGE_W = log2_ceil(WAYS);
        localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

        logic [AGE_W-1:0] age_q [SETS][WAYS];
        logic [AGE_W-1:0] age_d [SETS][WAYS];
        logic [AGE_W-1:0] best_age;
        logic [AGE_W-1:0] old_age;

        // Oldest way wins (lowest index on a tie); any invalid way
        // overrides that, and the descending scan leaves the lowest one.
        always_comb begin
            victim   = '0;
            best_age = age_q[idx][0];
            for (int w = 1; w < WAYS; w++) begin
                if (age_q[idx][w] > best_age) begin
                    best_age = age_q[idx][w];
                    victim   = WAY_W'(w);
                end
            end
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!valid_set[w]) begin
                    victim = WAY_W'(w);
                end
            end
        end

        // An invalid way is treated as the oldest when it is filled, so the
        // ages of a set always form a permutation once all ways are valid.
        always_comb begin
            age_d   = age_q;
            old_age = valid_set[upd_way] ? age_q[idx][upd_way] : AGE_MAX;
            if (upd_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == upd_way) begin
                        age_d[idx][w] = '0;
                    end else if (age_q[idx][w] < old_age) begin
                        age_d[idx][w] = age_q[idx][w] + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        age_q[s][w] <= '0;
                    end
                end
            end else begin
                age_q <= age_d;
            end
        end
    end

endmodule

// File: rtl/inscache_assoc.sv
// ---------------------------------------------------------------------------
// inscache_assoc
// Set-associative, blocking instruction cache with zero-cycle hits and a
// miss penalty of memory latency plus two cycles.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   caddress      - fetch byte address from the PC
//   cbusywait     - stalls the CPU while a miss is being serviced
//   Cins          - fetched instruction (0 when not hitting)
//   mread         - instruction-memory read request
//   maddress      - block address sent to memory
//   minstruction  - whole block returned by memory (word 0 in bits [31:0])
//   mbusywait     - memory busy
// Optional: define INSCACHE_STATS_EN to add saturating 16-bit hit_count
// and miss_count outputs.
// ---------------------------------------------------------------------------
module inscache_assoc
    import inscache_pkg::*;
#(
    parameter  int ADDR_W = 10,
    parameter  int WAYS   = 2,
    parameter  int SETS   = 8,
    parameter  int WORDS  = 4,
    localparam int OFF_W  = log2_ceil(WORDS) + 2,
    localparam int IDX_W  = log2_ceil(SETS),
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W,
    localparam int MA_W   = ADDR_W - OFF_W,
    localparam int BLK_W  = WORD_W * WORDS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] caddress,
    output logic              cbusywait,
    output logic [31:0]       Cins,
    output logic              mread,
    output logic [MA_W-1:0]   maddress,
    input  logic [BLK_W-1:0]  minstruction,
    input  logic              mbusywait
`ifdef INSCACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int WAY_W = (WAYS > 1) ? log2_ceil(WAYS) : 1;

    state_t             state_q, state_d;
    logic [MA_W-1:0]    blk_addr_q, blk_addr_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    valid_d [SETS];

    logic [TAG_W-1:0]   tag_mem  [WAYS][SETS];
    logic [BLK_W-1:0]   data_mem [WAYS][SETS];

    logic [TAG_W-1:0]   cur_tag;
    logic [IDX_W-1:0]   cur_idx;
    logic [OFF_W-3:0]   cur_word;
    logic [TAG_W-1:0]   fill_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [WAYS-1:0]    hit_vec;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [BLK_W-1:0]   hit_blk;
    logic [WAY_W-1:0]   victim;
    logic [IDX_W-1:0]   lru_idx;
    logic               lru_en;
    logic [WAY_W-1:0]   lru_way;
    logic               fill_en;
    logic               unused_byte;

    assign cur_tag     = caddress[ADDR_W-1:OFF_W+IDX_W];
    assign cur_idx     = caddress[OFF_W+IDX_W-1:OFF_W];
    assign cur_word    = caddress[OFF_W-1:2];
    assign fill_tag    = blk_addr_q[MA_W-1:IDX_W];
    assign fill_idx    = blk_addr_q[IDX_W-1:0];
    assign unused_byte = ^caddress[1:0];

    // Lookup: tag compare across all ways of the indexed set; a hit only
    // counts in IDLE so stale addresses cannot hit mid-fill.
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[cur_idx][w] && (tag_mem[w][cur_idx] == cur_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
        hit     = (state_q == IDLE) && (|hit_vec);
        hit_blk = data_mem[hit_way][cur_idx];
        Cins    = hit ? hit_blk[cur_word*WORD_W +: WORD_W] : '0;
    end

    // During a fill the LRU looks at the latched set, not the live address.
    assign lru_idx = (state_q == IDLE) ? cur_idx : fill_idx;

    inscache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clock     (clock),
        .reset     (reset),
        .idx       (lru_idx),
        .valid_set (valid_q[lru_idx]),
        .upd_en    (lru_en),
        .upd_way   (lru_way),
        .victim    (victim)
    );

    always_comb begin
        state_d    = state_q;
        blk_addr_d = blk_addr_q;
        valid_d    = valid_q;
        lru_en     = 1'b0;
        lru_way    = hit_way;
        fill_en    = 1'b0;
        cbusywait  = 1'b1;
        mread      = 1'b0;
        maddress   = '0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    cbusywait = 1'b0;
                    lru_en    = 1'b1;
                end else begin
                    state_d    = MEM_READ;
                    blk_addr_d = caddress[ADDR_W-1:OFF_W];
                end
            end
            MEM_READ: begin
                mread    = 1'b1;
                maddress = blk_addr_q;
                if (!mbusywait) begin
                    state_d                   = UPDATE;
                    fill_en                   = 1'b1;
                    lru_en                    = 1'b1;
                    lru_way                   = victim;
                    valid_d[fill_idx][victim] = 1'b1;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The CPU is released while reset is held, even though every
        // lookup misses with the valid bits cleared.
        if (reset) begin
            cbusywait = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            blk_addr_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            blk_addr_q <= blk_addr_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            data_mem[victim][fill_idx] <= minstruction;
            tag_mem[victim][fill_idx]  <= fill_tag;
        end
    end

`ifdef INSCACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if ((state_q == IDLE) && !hit && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_inscache_assoc.sv
// ---------------------------------------------------------------------------
// tb_inscache_assoc
// Self-checking bench for inscache_assoc (ADDR_W=10, WAYS=2, SETS=8,
// WORDS=4). Memory contents are a fixed function of the block address, and
// a timestamp-based LRU model predicts hits and misses. Every task starts
// and ends exactly on a falling clock edge; inputs change there and outputs
// are sampled 1 time unit later.
// Define INSCACHE_STATS_EN to also exercise hit_count / miss_count.
// ---------------------------------------------------------------------------
module tb_inscache_assoc;

    localparam int ADDR_W = 10;
    localparam int WAYS   = 2;
    localparam int SETS   = 8;
    localparam int WORDS  = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [9:0]   caddress;
    logic         cbusywait;
    logic [31:0]  Cins;
    logic         mread;
    logic [5:0]   maddress;
    logic [127:0] minstruction;
    logic         mbusywait;
`ifdef INSCACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: tag per slot, valid flag, last-use timestamp.
    bit mdl_valid [SETS][WAYS];
    int mdl_tag   [SETS][WAYS];
    int mdl_stamp [SETS][WAYS];
    int mdl_now = 0;

    inscache_assoc #(
        .ADDR_W (ADDR_W),
        .WAYS   (WAYS),
        .SETS   (SETS),
        .WORDS  (WORDS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .caddress     (caddress),
        .cbusywait    (cbusywait),
        .Cins         (Cins),
        .mread        (mread),
        .maddress     (maddress),
        .minstruction (minstruction),
        .mbusywait    (mbusywait)
`ifdef INSCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [31:0] mem_word(input int blk, input int w);
        return 32'hC0DE_0000 | 32'(blk << 4) | 32'(w);
    endfunction

    function automatic logic [127:0] mem_block(input int blk);
        logic [127:0] b;
        for (int w = 0; w < WORDS; w++) begin
            b[w*32 +: 32] = mem_word(blk, w);
        end
        return b;
    endfunction

    function automatic void mdl_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                mdl_valid[s][w] = 1'b0;
            end
        end
    endfunction

    function automatic bit mdl_hit(input logic [9:0] a);
        int s = int'(a[6:4]);
        for (int w = 0; w < WAYS; w++) begin
            if (mdl_valid[s][w] && mdl_tag[s][w] == int'(a[9:7])) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Mark the block most recent, allocating a slot (free one first,
    // otherwise the one used longest ago) if it is not present.
    function automatic void mdl_touch(input logic [9:0] a);
        int s = int'(a[6:4]);
        int t = int'(a[9:7]);
        int slot = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (mdl_valid[s][w] && mdl_tag[s][w] == t) slot = w;
        end
        if (slot < 0) begin
            for (int w = 0; w < WAYS; w++) begin
                if (!mdl_valid[s][w] && slot < 0) slot = w;
            end
        end
        if (slot < 0) begin
            slot = 0;
            for (int w = 1; w < WAYS; w++) begin
                if (mdl_stamp[s][w] < mdl_stamp[s][slot]) slot = w;
            end
        end
        mdl_valid[s][slot] = 1'b1;
        mdl_tag[s][slot]   = t;
        mdl_now++;
        mdl_stamp[s][slot] = mdl_now;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mdl_clear();
    endtask

    // One fetch of addr; a miss is served by memory after lat busy cycles.
    task automatic access(input logic [9:0] addr, input int lat, output bit obs_hit);
        int          blk;
        bit          exp_hit;
        logic [31:0] exp_word;
        blk      = int'(addr[9:4]);
        exp_word = mem_word(blk, int'(addr[3:2]));
        exp_hit  = mdl_hit(addr);
        caddress = addr;
        #1;
        obs_hit = (cbusywait === 1'b0);
        tests++;
        if (obs_hit !== exp_hit) begin
            fails++;
            $display("[TB] FAIL lookup addr=%h: hit got %0d expected %0d", addr, obs_hit, exp_hit);
        end
        if (exp_hit) begin
            tests++;
            if (Cins !== exp_word || mread !== 1'b0) begin
                fails++;
                $display("[TB] FAIL hit_data addr=%h: Cins=%h mread=%b expected Cins=%h mread=0",
                         addr, Cins, mread, exp_word);
            end
            mdl_touch(addr);
            @(posedge clock);
            @(negedge clock);
        end else begin
            tests++;
            if (Cins !== 32'h0) begin
                fails++;
                $display("[TB] FAIL miss_cins addr=%h: got %h expected 0", addr, Cins);
            end
            @(posedge clock);
            for (int c = 0; c <= lat; c++) begin
                @(negedge clock);
                if (c == lat) begin
                    mbusywait    = 1'b0;
                    minstruction = mem_block(blk);
                end
                #1;
                tests++;
                if (mread !== 1'b1 || maddress !== addr[9:4] || cbusywait !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL mem_read addr=%h cycle %0d: mread=%b maddress=%h busy=%b expected 1 %h 1",
                             addr, c, mread, maddress, cbusywait, addr[9:4]);
                end
                @(posedge clock);
            end
            @(negedge clock);
            mbusywait    = 1'b1;
            minstruction = {4{$urandom()}};
            #1;
            tests++;
            if (mread !== 1'b0 || maddress !== 6'h0 || cbusywait !== 1'b1) begin
                fails++;
                $display("[TB] FAIL update addr=%h: mread=%b maddress=%h busy=%b expected 0 00 1",
                         addr, mread, maddress, cbusywait);
            end
            @(posedge clock);
            @(negedge clock);
            #1;
            tests++;
            if (cbusywait !== 1'b0 || Cins !== exp_word) begin
                fails++;
                $display("[TB] FAIL refill_hit addr=%h: busy=%b Cins=%h expected 0 %h",
                         addr, cbusywait, Cins, exp_word);
            end
            mdl_touch(addr);
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        caddress     = 10'h000;
        mbusywait    = 1'b1;
        minstruction = '0;
        @(posedge clock);
        @(negedge clock);
        #1;
        tests++;
        if (mread !== 1'b0 || maddress !== 6'h0 || cbusywait !== 1'b0 || Cins !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_state: mread=%b maddress=%h busy=%b Cins=%h expected 0 00 0 0",
                     mread, maddress, cbusywait, Cins);
        end
`ifdef INSCACHE_STATS_EN
        tests++;
        if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
            fails++;
            $display("[TB] FAIL reset_stats: hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
        end
`endif
        @(negedge clock);
        reset = 1'b0;
        mdl_clear();
    endtask

    task automatic test_cold_miss();
        bit h;
        access(10'h000, 5, h);
        tests++;
        if (h !== 1'b0) begin
            fails++;
            $display("[TB] FAIL cold_miss: hit got %0d expected 0", h);
        end
    endtask

    task automatic test_sequential_hits();
        bit h;
        for (int i = 1; i < 4; i++) begin
            access(10'(i * 4), 1, h);
            tests++;
            if (h !== 1'b1) begin
                fails++;
                $display("[TB] FAIL seq_hit word %0d: hit got %0d expected 1", i, h);
            end
        end
    endtask

    task automatic test_lru_eviction();
        logic [9:0] addrs [6] = '{10'h000, 10'h080, 10'h080, 10'h100, 10'h080, 10'h000};
        bit         wants [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bit         h;
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            access(addrs[i], 2, h);
            tests++;
            if (h !== wants[i]) begin
                fails++;
                $display("[TB] FAIL lru step %0d addr=%h: hit got %0d expected %0d",
                         i, addrs[i], h, wants[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        bit h;
        access(10'h000, 1, h);
        caddress = 10'h200;
        @(posedge clock);
        @(negedge clock);
        #1;
        tests++;
        if (mread !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midfill_mread: got %b expected 1", mread);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        tests++;
        if (mread !== 1'b0 || maddress !== 6'h0 || cbusywait !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midfill_reset: mread=%b maddress=%h busy=%b expected 0 00 0",
                     mread, maddress, cbusywait);
        end
        @(negedge clock);
        reset = 1'b0;
        mdl_clear();
        access(10'h000, 2, h);
        tests++;
        if (h !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midfill_after: hit got %0d expected 0", h);
        end
    endtask

    task automatic test_addr_change();
        bit h;
        pulse_reset();
        caddress = 10'h000;
        @(posedge clock);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c == 3) caddress = 10'h040;
            #1;
            tests++;
            if (mread !== 1'b1 || maddress !== 6'h00) begin
                fails++;
                $display("[TB] FAIL addr_change cycle %0d: mread=%b maddress=%h expected 1 00", c, mread, maddress);
            end
            @(posedge clock);
        end
        @(negedge clock);
        mbusywait    = 1'b0;
        minstruction = mem_block(0);
        @(posedge clock);
        @(negedge clock);
        mbusywait    = 1'b1;
        minstruction = {4{$urandom()}};
        mdl_touch(10'h000);
        @(posedge clock);
        @(negedge clock);
        #1;
        tests++;
        if (cbusywait !== 1'b1) begin
            fails++;
            $display("[TB] FAIL addr_change_remiss: busy got %b expected 1", cbusywait);
        end
        @(posedge clock);
        @(negedge clock);
        mbusywait    = 1'b0;
        minstruction = mem_block(4);
        #1;
        tests++;
        if (mread !== 1'b1 || maddress !== 6'h04) begin
            fails++;
            $display("[TB] FAIL addr_change_new: mread=%b maddress=%h expected 1 04", mread, maddress);
        end
        @(posedge clock);
        @(negedge clock);
        mbusywait = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        tests++;
        if (cbusywait !== 1'b0 || Cins !== mem_word(4, 0)) begin
            fails++;
            $display("[TB] FAIL addr_change_hit: busy=%b Cins=%h expected 0 %h", cbusywait, Cins, mem_word(4, 0));
        end
        mdl_touch(10'h040);
        @(posedge clock);
        @(negedge clock);
        access(10'h000, 1, h);
        tests++;
        if (h !== 1'b1) begin
            fails++;
            $display("[TB] FAIL addr_change_kept: hit got %0d expected 1", h);
        end
    endtask

    task automatic test_random();
        bit         h;
        logic [9:0] a;
        pulse_reset();
        for (int i = 0; i < 100; i++) begin
            a[9:7] = 3'($urandom_range(0, 3));
            a[6:4] = 3'($urandom_range(0, 1));
            a[3:0] = 4'($urandom());
            access(a, $urandom_range(0, 3), h);
        end
    endtask

`ifdef INSCACHE_STATS_EN
    task automatic test_stats();
        bit h;
        pulse_reset();
        access(10'h000, 3, h);
        access(10'h004, 1, h);
        access(10'h008, 1, h);
        access(10'h00C, 1, h);
        #1;
        tests++;
        if (miss_count !== 16'd1 || hit_count !== 16'd4) begin
            fails++;
            $display("[TB] FAIL stats: miss=%0d hit=%0d expected 1 4", miss_count, hit_count);
        end
        @(negedge clock);
    endtask
`endif

    initial begin
        reset        = 1'b1;
        caddress     = 10'h000;
        mbusywait    = 1'b1;
        minstruction = '0;
        mdl_clear();
        @(negedge clock);
        test_reset();
        test_cold_miss();
        test_sequential_hits();
        test_lru_eviction();
        test_reset_mid_fill();
        test_addr_change();
        test_random();
`ifdef INSCACHE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inscache_assoc.md
INSCACHE_ASSOC -- requirements
Module: inscache_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, 10, fetch address width in bits (byte address).
REQ-002 SHALL have parameter WAYS, 2, associativity; legal values 1, 2, 4.
REQ-003 SHALL have parameter SETS, 8, number of sets; power of two, at least 2.
REQ-004 SHALL have parameter WORDS, 4, 32-bit words per block; power of two, at least 2.
REQ-005 SHALL derive OFF_W=log2(WORDS)+2, IDX_W=log2(SETS), TAG_W=ADDR_W-OFF_W-IDX_W, and MA_W=ADDR_W-OFF_W.
REQ-006 SHALL have the following ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- caddress  in  ADDR_W  fetch address from the PC.
- cbusywait  out  1  stalls the CPU.
- Cins  out  32  fetched instruction.
- mread  out  1  instruction-memory read request.
- maddress  out  MA_W  block address sent to memory.
- minstruction  in  32*WORDS  block returned by memory.
- mbusywait  in  1  memory busy.

Function
REQ-007 SHALL split caddress into tag [ADDR_W-1:OFF_W+IDX_W], index [OFF_W+IDX_W-1:OFF_W] and word [OFF_W-1:2]; bits [1:0] are ignored.
REQ-008 SHALL flag a hit, combinationally in IDLE, when any way of the indexed set is valid with a matching tag.
REQ-009 SHALL drive Cins combinationally with the selected word of the hitting way on a hit, and 0 otherwise; word 0 occupies bits [31:0].
REQ-010 SHALL drive cbusywait as follows:
- 0 in IDLE on a hit (zero-cycle hit latency).
- 1 in IDLE on a miss, and 1 in every other state.
REQ-011 SHALL use FSM states IDLE, MEM_READ and UPDATE:
- IDLE to MEM_READ on a miss.
- MEM_READ holds while mbusywait=1, and moves to UPDATE on the first edge where mbusywait=0.
- UPDATE to IDLE unconditionally.
REQ-012 SHALL latch the block address caddress[ADDR_W-1:OFF_W] on IDLE to MEM_READ, and hold mread=1 with maddress equal to that latched value throughout MEM_READ.
REQ-013 SHALL drive mread=0 and maddress=0 outside MEM_READ.
REQ-014 SHALL, on the MEM_READ to UPDATE edge, write minstruction into the victim way, then set its valid bit and tag and mark it most-recently-used.
REQ-015 SHALL choose the victim as the lowest-indexed invalid way; if all ways are valid, the least-recently-used way.
REQ-016 SHALL keep true LRU per set as log2(WAYS)-bit age counters:
- The accessed way's age becomes 0.
- Ways younger than its old age increment.
- Updated on each IDLE edge with a hit, and on fill.
REQ-017 SHALL give a miss penalty of memory latency plus 2 cycles; after UPDATE the returning IDLE lookup hits.
REQ-018 SHALL ignore caddress changes during MEM_READ and UPDATE: the latched fill completes, and IDLE then re-evaluates the current caddress.
REQ-019 SHALL, when WAYS=1, behave as direct-mapped with no LRU storage.

Reset
REQ-020 SHALL, while reset is high and from any state (including mid-fill), force state IDLE, mread=0, maddress=0 and cbusywait=0, and clear all valid bits and LRU ages.
REQ-021 SHALL leave data and tag arrays unreset.

Configuration
REQ-022 SHALL, with INSCACHE_STATS_EN defined, add 16-bit outputs hit_count and miss_count:
- hit_count increments on each IDLE edge with a hit.
- miss_count increments on each IDLE to MEM_READ edge.
- Both saturate at 0xFFFF and reset to 0.
REQ-023 SHALL, without INSCACHE_STATS_EN, omit both ports and counters entirely.

Structure
REQ-024 SHALL place the state enum (IDLE, MEM_READ, UPDATE), the 32-bit word-width constant and the log2 helper in package inscache_pkg.
REQ-025 SHALL implement per-set age storage and victim selection in sub-module inscache_lru (parameters WAYS, SETS).

Verification
REQ-026 SHALL cover a cold miss: after reset, caddress=0x000 with mbusywait high 5 cycles gives mread=1, maddress=0x00 and cbusywait=1; Cins=word0 with cbusywait=0 two edges after mbusywait falls.
REQ-027 SHALL cover sequential hits: after that fill, caddress 0x004, 0x008, 0x00C gives Cins=words 1..3, cbusywait=0 and mread never asserted.
REQ-028 SHALL cover LRU eviction:
- Fill 0x000 and 0x080 (set 0, tags 0 and 1), then access 0x080.
- Access 0x100: it evicts tag 0.
- Then 0x080 hits and 0x000 misses.
REQ-029 SHALL cover reset mid-fill: reset asserted in MEM_READ drops mread immediately; a subsequent 0x000 access misses.
REQ-030 SHALL cover an address change mid-fill: mbusywait high 20 cycles with caddress moving 0x000 to 0x040 keeps maddress=0x00; after UPDATE, a new miss drives maddress=0x04.
REQ-031 SHALL cover stats with INSCACHE_STATS_EN: a cold fill of 0x000 followed by 0x004, 0x008, 0x00C gives miss_count=1 and hit_count=4.
